// File: rtl/slice_alu_seq.sv
// slice_alu_seq: multi-cycle ALU sequencer. Operands of W = SLICE_W*N_SLICE
// bits are processed one slice per clock through a single slice ALU.
// Arithmetic/logic ops walk LSB-first; compares walk MSB-first and stop at
// the first deciding slice.
module slice_alu_seq #(
  parameter int SLICE_W = 8,
  parameter int N_SLICE = 2,
  localparam int W = SLICE_W * N_SLICE
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         start,
  input  logic         abort,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         overflow,
  output logic         compare
);

  localparam int IDX_W = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N_SLICE - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LT  = 3'd5;
  localparam logic [2:0] OP_LTU = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [W-1:0]       a_r, b_r, a_s, b_s, result_s;
  logic [2:0]         op_r, op_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic               cin_r, cin_s;
  logic               busy_s, done_s, zero_s, carry_s, overflow_s, compare_s;
  logic [SLICE_W-1:0] a_sl_s, b_sl_s, b_eff_s, slice_res_s;
  logic [SLICE_W:0]   sum_s;
  logic               arith_s, ovf_sl_s, decide_s, cmp_val_s;

  // Slice ALU: select the current slice and compute its arithmetic/logic result.
  always_comb begin
    a_sl_s  = a_r[idx_r*SLICE_W +: SLICE_W];
    b_sl_s  = b_r[idx_r*SLICE_W +: SLICE_W];
    arith_s = (op_r == OP_ADD) || (op_r == OP_SUB);
    if (op_r == OP_SUB) begin
      b_eff_s = ~b_sl_s;
    end else begin
      b_eff_s = b_sl_s;
    end
    sum_s    = {1'b0, a_sl_s} + {1'b0, b_eff_s} + {{SLICE_W{1'b0}}, cin_r};
    // Carry into the top bit differs from carry out exactly when the operand
    // signs agree but the sum sign does not.
    ovf_sl_s = (a_sl_s[SLICE_W-1] == b_eff_s[SLICE_W-1]) &&
               (sum_s[SLICE_W-1] != a_sl_s[SLICE_W-1]);
    case (op_r)
      OP_ADD, OP_SUB: slice_res_s = sum_s[SLICE_W-1:0];
      OP_AND:         slice_res_s = a_sl_s & b_sl_s;
      OP_OR:          slice_res_s = a_sl_s | b_sl_s;
      OP_XOR:         slice_res_s = a_sl_s ^ b_sl_s;
      default:        slice_res_s = {SLICE_W{1'b0}};
    endcase
  end

  // Compare step: decide whether the current (MSB-first) slice settles the outcome.
  always_comb begin
    decide_s  = 1'b0;
    cmp_val_s = 1'b0;
    case (op_r)
      OP_LT: begin
        if ((idx_r == IDX_TOP) && (a_sl_s[SLICE_W-1] != b_sl_s[SLICE_W-1])) begin
          decide_s  = 1'b1;
          cmp_val_s = a_sl_s[SLICE_W-1];
        end else if (a_sl_s != b_sl_s) begin
          decide_s  = 1'b1;
          cmp_val_s = (a_sl_s < b_sl_s);
        end else if (idx_r == IDX_ZERO) begin
          decide_s  = 1'b1;
          cmp_val_s = 1'b0;
        end else begin
          decide_s  = 1'b0;
        end
      end
      OP_LTU: begin
        if (a_sl_s != b_sl_s) begin
          decide_s  = 1'b1;
          cmp_val_s = (a_sl_s < b_sl_s);
        end else if (idx_r == IDX_ZERO) begin
          decide_s  = 1'b1;
          cmp_val_s = 1'b0;
        end else begin
          decide_s  = 1'b0;
        end
      end
      OP_EQ: begin
        if (a_sl_s != b_sl_s) begin
          decide_s  = 1'b1;
          cmp_val_s = 1'b0;
        end else if (idx_r == IDX_ZERO) begin
          decide_s  = 1'b1;
          cmp_val_s = 1'b1;
        end else begin
          decide_s  = 1'b0;
        end
      end
      default: begin
        decide_s  = 1'b0;
        cmp_val_s = 1'b0;
      end
    endcase
  end

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    a_s        = a_r;
    b_s        = b_r;
    op_s       = op_r;
    idx_s      = idx_r;
    cin_s      = cin_r;
    busy_s     = busy;
    done_s     = 1'b0;
    result_s   = result;
    zero_s     = zero;
    carry_s    = carry;
    overflow_s = overflow;
    compare_s  = compare;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_s        = a;
          b_s        = b;
          op_s       = op;
          carry_s    = 1'b0;
          overflow_s = 1'b0;
          compare_s  = 1'b0;
          busy_s     = 1'b1;
          state_s    = RUN;
          if (op < OP_LT) begin
            idx_s = IDX_ZERO;
            cin_s = (op == OP_SUB);
          end else begin
            idx_s = IDX_TOP;
            cin_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else if (op_r < OP_LT) begin
          result_s[idx_r*SLICE_W +: SLICE_W] = slice_res_s;
          cin_s = sum_s[SLICE_W];
          if (idx_r == IDX_TOP) begin
            carry_s    = arith_s & sum_s[SLICE_W];
            overflow_s = arith_s & ovf_sl_s;
            zero_s     = (result_s == {W{1'b0}});
            busy_s     = 1'b0;
            done_s     = 1'b1;
            state_s    = IDLE;
          end else begin
            idx_s = idx_r + 1'b1;
          end
        end else begin
          if (decide_s) begin
            result_s   = {{(W-1){1'b0}}, cmp_val_s};
            compare_s  = cmp_val_s;
            zero_s     = ~cmp_val_s;
            carry_s    = 1'b0;
            overflow_s = 1'b0;
            busy_s     = 1'b0;
            done_s     = 1'b1;
            state_s    = IDLE;
          end else begin
            idx_s = idx_r - 1'b1;
          end
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, operand and output registers; Reset clears everything at once.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r  <= IDLE;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      op_r     <= 3'd0;
      idx_r    <= IDX_ZERO;
      cin_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= {W{1'b0}};
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      compare  <= 1'b0;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      op_r     <= op_s;
      idx_r    <= idx_s;
      cin_r    <= cin_s;
      busy     <= busy_s;
      done     <= done_s;
      result   <= result_s;
      zero     <= zero_s;
      carry    <= carry_s;
      overflow <= overflow_s;
      compare  <= compare_s;
    end
  end

endmodule

// File: tb/tb_slice_alu_seq.sv
// Testbench for slice_alu_seq: two instances (8x2 and 8x4 slices), each with
// its own stimulus process, whole-word reference model and done-driven monitor.
module tb_slice_alu_seq;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        cmp;
    int          lat;
    int          acc;
  } exp_t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NS = (g == 0) ? 2 : 4;
    localparam int W  = 8 * NS;

    logic         rst_n, start, abort;
    logic [2:0]   op;
    logic [W-1:0] a, b, result;
    logic         busy, done, zero, carry, overflow, compare;
    int           cyc = 0;
    exp_t         q[$];
    bit           fin = 1'b0;

    slice_alu_seq #(.SLICE_W(8), .N_SLICE(NS)) dut (
      .Clock(clk), .Reset(rst_n), .start(start), .abort(abort), .op(op),
      .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero),
      .carry(carry), .overflow(overflow), .compare(compare)
    );

    // cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model on whole words with plain arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      logic [W:0] s;
      int top;
      e.res = 32'd0; e.carry = 1'b0; e.ovf = 1'b0; e.cmp = 1'b0; e.lat = NS; e.acc = 0;
      case (o)
        3'd0: begin
          s = {1'b0, x} + {1'b0, y};
          e.res = 32'(s[W-1:0]); e.carry = s[W];
          e.ovf = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        end
        3'd1: begin
          s = {1'b0, x} - {1'b0, y};
          e.res = 32'(s[W-1:0]); e.carry = (x >= y);
          e.ovf = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        end
        3'd2: e.res = 32'(x & y);
        3'd3: e.res = 32'(x | y);
        3'd4: e.res = 32'(x ^ y);
        default: begin
          if (o == 3'd5)      e.cmp = ($signed(x) < $signed(y));
          else if (o == 3'd6) e.cmp = (x < y);
          else                e.cmp = (x == y);
          top = -1;
          for (int i = 0; i < NS; i++) if (x[i*8 +: 8] != y[i*8 +: 8]) top = i;
          e.lat = (top < 0) ? NS : NS - top;
          e.res = {31'd0, e.cmp};
        end
      endcase
      e.zero = (e.res == 32'd0);
      return e;
    endfunction

    // Monitor: each done pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("result",   32'(result),   e.res);
          chk("zero",     32'(zero),     32'(e.zero));
          chk("carry",    32'(carry),    32'(e.carry));
          chk("overflow", 32'(overflow), 32'(e.ovf));
          chk("compare",  32'(compare),  32'(e.cmp));
          chk("latency",  32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end

    // Issue one op; called at a negedge, returns at a negedge.
    // mode 0: normal, 1: abort mid-run, 2: Reset mid-run.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int mode);
      exp_t e;
      int k, guard;
      guard = 0;
      while (busy && guard < 200) begin
        start = ($urandom_range(0, 2) == 0);
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        guard++;
        @(negedge clk);
      end
      if (busy) begin
        chk("accept_timeout", 32'(busy), 32'd0);
        start = 1'b0;
        return;
      end
      start = 1'b1; op = o; a = x; b = y;
      abort = 1'($urandom_range(0, 1));
      e = model(o, x, y);
      e.acc = cyc + 1;
      if (mode == 0) q.push_back(e);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      a = W'($urandom); b = W'($urandom);
      chk("accepted_busy", 32'(busy), 32'd1);
      if (mode == 1) begin
        k = int'($urandom_range(e.lat, 1));
        for (int j = 1; j < k; j++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",     32'(busy),     32'd0);
        chk("abort_done",     32'(done),     32'd0);
        chk("abort_carry",    32'(carry),    32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        chk("abort_compare",  32'(compare),  32'd0);
      end else if (mode == 2) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_result",   32'(result),   32'd0);
        chk("rst_zero",     32'(zero),     32'd0);
        chk("rst_carry",    32'(carry),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_compare",  32'(compare),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        k = 0;
      end
    endtask

    // stimulus: reset check, directed cases, then randomized traffic
    initial begin
      logic [W-1:0] x, y;
      int r, guard, mode;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 3'd0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy",    32'(busy),    32'd0);
      chk("reset_done",    32'(done),    32'd0);
      chk("reset_result",  32'(result),  32'd0);
      chk("reset_flags",   32'({zero, carry, overflow, compare}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      if (NS == 2) begin
        issue(3'd0, W'(32'h00FF), W'(32'h0001), 0);
        issue(3'd0, W'(32'hFFFF), W'(32'h0001), 0);
        issue(3'd1, W'(32'h8000), W'(32'h0001), 0);
        issue(3'd5, W'(32'h8000), W'(32'h0001), 0);
        issue(3'd5, W'(32'h1234), W'(32'h1235), 0);
        issue(3'd5, W'(32'h1235), W'(32'h1235), 0);
        issue(3'd7, W'(32'h1200), W'(32'h1300), 0);
        issue(3'd6, W'(32'h8000), W'(32'h0001), 0);
        issue(3'd0, W'(32'h1234), W'(32'h4321), 1);
        issue(3'd0, W'(32'h1234), W'(32'h4321), 2);
      end else begin
        issue(3'd0, W'(32'h00FF_FFFF), W'(32'h0000_0001), 0);
        issue(3'd5, W'(32'h8000_0000), W'(32'h0000_0001), 0);
        issue(3'd7, W'(32'hDEAD_BEEF), W'(32'hDEAD_BEEF), 0);
        issue(3'd1, W'(32'h0000_0000), W'(32'h0000_0001), 0);
        issue(3'd6, W'(32'h1234_5678), W'(32'h1234_5679), 1);
      end
      repeat (150) begin
        x = W'($urandom);
        case ($urandom_range(0, 2))
          0:       y = W'($urandom);
          1:       y = x;
          default: y = x ^ W'($urandom_range(1, 255));
        endcase
        r = int'($urandom_range(0, 19));
        mode = (r == 0) ? 2 : ((r < 4) ? 1 : 0);
        issue(3'($urandom), x, y, mode);
      end
      guard = 0;
      while (q.size() != 0 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk("drain", 32'(q.size()), 32'd0);
      fin = 1'b1;
    end
  end

  // end of run: wait for both configurations, then report
  initial begin
    int guard;
    guard = 0;
    while (!(cfg[0].fin && cfg[1].fin) && guard < 50000) begin
      @(posedge clk);
      guard++;
    end
    if (!(cfg[0].fin && cfg[1].fin)) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=%0d cycles required=completion", guard);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slice_alu_seq.md
Name: slice_alu_seq

Overview:
- Parametrised multi-cycle ALU sequencer for the calculator datapath.
- Processes W = SLICE_W*N_SLICE-bit operands one SLICE_W slice per clock through a single slice ALU.
- Arithmetic and logic ops walk the slices LSB-first; compare ops walk them MSB-first and terminate early.
- Sits between the key-scan operand registers and the display/music logic, and supersedes the fixed 2x8-bit sequencer.

Parameters:
- SLICE_W, 8, width of one ALU slice in bits (>=2).
- N_SLICE, 2, number of slices per operand (>=1).
- W, SLICE_W*N_SLICE, derived operand width; not overridden independently.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on an edge where busy=0.
- abort  in  1  synchronous cancel of an operation in progress.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LT (signed), 6 LTU (unsigned), 7 EQ.
- a  in  W  operand A; captured at accept.
- b  in  W  operand B; captured at accept.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  W  result register.
- zero  out  1  result==0.
- carry  out  1  carry out of the top slice (ADD/SUB).
- overflow  out  1  signed overflow (ADD/SUB).
- compare  out  1  outcome of LT, LTU or EQ.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state=IDLE;
  - busy=0, done=0;
  - result, zero, carry, overflow and compare all 0;
  - internal operand, op and slice-index registers cleared.
- States: IDLE, RUN.
- IDLE:
  - done drops to 0 one cycle after its assertion.
  - When start=1 on an edge: capture a, b and op; clear carry, overflow and compare; set busy=1.
  - The slice index is set to 0 for ops 0-4 and to N_SLICE-1 for ops 5-7; go to RUN.
- Start in the same cycle done=1 is accepted (busy=0 at that point).
- Start while busy=1 is ignored and does not affect the running operation.
- RUN, ops 0-4 (one slice per edge, index i ascending):
  - ADD: slice = A_i + B_i + cin.
  - SUB: slice = A_i + ~B_i + cin.
  - Internal cin is 0 for ADD and 1 for SUB on slice 0; afterwards it is the previous slice's carry-out.
  - AND, OR and XOR are bitwise per slice; carry and overflow stay 0.
  - result[i*SLICE_W +: SLICE_W] is written each edge.
  - On slice N_SLICE-1 the same edge does all of the following:
    - carry = top carry-out; for SUB, 1 means no borrow;
    - overflow = carry into the top bit XOR carry out of the top bit;
    - zero = (full new result == 0);
    - busy=0, done=1, state=IDLE.
  - Latency is exactly N_SLICE edges after the accept edge.
- RUN, ops 5-7 (index i descending from the top slice):
  - LT, top slice: if the sign bits differ, decide immediately, compare = sign of A.
  - LT/LTU: if A_i != B_i, decide compare = (A_i < B_i), with the top slice already handled as above for LT. Otherwise continue to i-1.
  - EQ: if A_i != B_i, decide compare=0; otherwise continue.
  - If all slices are equal: LT/LTU give compare=0 and EQ gives compare=1.
  - On the deciding edge:
    - result = {W-1 zeros, compare};
    - zero = ~compare;
    - carry=0, overflow=0;
    - busy=0, done=1, state=IDLE.
  - Latency is 1..N_SLICE edges (early termination).
- abort=1 in RUN: return to IDLE with busy=0 and done=0.
  - result keeps its partially written slices.
  - The flags keep their values from accept, i.e. cleared.
- abort in IDLE has no effect; abort takes priority over the slice step on the same edge.
- The outputs result, flags and compare hold their values until the next accept or Reset.
- Reset asserted mid-operation aborts immediately with no done pulse.

Test Plan:
- SLICE_W=8, N_SLICE=2:
  - ADD a=0x00FF, b=0x0001 -> done exactly 2 cycles after accept; result=0x0100, carry=0, zero=0, overflow=0.
  - ADD 0xFFFF+0x0001 -> result=0x0000, zero=1, carry=1, overflow=0.
  - SUB 0x8000-0x0001 -> result=0x7FFF, carry=1, overflow=1.
- LT, N_SLICE=2:
  - a=0x8000, b=0x0001 -> done 1 cycle after accept; compare=1, result=0x0001.
  - a=0x1234, b=0x1235 -> done 2 cycles after accept; compare=1.
  - a=0x1235, b=0x1235 -> compare=0, zero=1.
- EQ a=0x1200, b=0x1300 -> done after 1 cycle, compare=0.
- LTU a=0x8000, b=0x0001 -> compare=0.
- Control:
  - start pulsed while busy (with different operands) -> ignored; original result delivered.
  - abort mid-RUN -> busy=0, no done pulse.
  - Reset low mid-RUN -> all outputs 0 asynchronously.
- SLICE_W=8, N_SLICE=4:
  - ADD 0x00FFFFFF+1 -> result=0x01000000; done after 4 cycles.
  - Back-to-back start on the done cycle -> accepted with no idle gap.
